// File: rtl/branch_pc_unit.sv
// Program counter and conditional-branch stage: evaluates FLCNZ conditions,
// redirects the PC on taken Bcond/Jcond, flushes fetch, and resolves Scond.
module branch_pc_unit #(
    parameter int          PC_W      = 16,
    parameter int          FLUSH_CYC = 2,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic            CLK,
    input  logic            RESETn,
    input  logic            instr_valid,
    input  logic            br_en,
    input  logic            jmp_en,
    input  logic            scond_en,
    input  logic [3:0]      cond,
    input  logic [PC_W-1:0] disp,
    input  logic [PC_W-1:0] target,
    input  logic [4:0]      flags,
    input  logic            flag_pend,
    input  logic            stall,
    output logic [PC_W-1:0] pc,
    output logic            instr_ack,
    output logic            flush,
    output logic            taken,
    output logic            scond_val
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_FLAG = 2'd1,
        FLUSH     = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] RST_PC     = RESET_PC[PC_W-1:0];
    localparam logic [1:0]      FLUSH_LAST = 2'(FLUSH_CYC - 1);
    localparam logic [3:0]      COND_UC    = 4'hE;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [1:0]      fcnt_q;
    logic            ack_q;
    logic            flush_q;
    logic            taken_q;
    logic            scond_q;

    logic            cond_true;
    logic            br_only;
    logic            jmp_only;
    logic            sc_only;
    logic            is_cond_instr;
    logic            must_wait;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;

    // flags = {F, L, C, N, Z}
    function automatic logic eval_cond(input logic [3:0] c, input logic [4:0] f);
        logic fF, fL, fC, fN, fZ;
        logic r;
        {fF, fL, fC, fN, fZ} = f;
        case (c)
            4'h0:    r = fZ;
            4'h1:    r = !fZ;
            4'h2:    r = fC;
            4'h3:    r = !fC;
            4'h4:    r = fL;
            4'h5:    r = !fL;
            4'h6:    r = fN;
            4'h7:    r = !fN;
            4'h8:    r = fF;
            4'h9:    r = !fF;
            4'hA:    r = !fL && !fZ;
            4'hB:    r = fL || fZ;
            4'hC:    r = !fN && !fZ;
            4'hD:    r = fN || fZ;
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // More than one class enable high degrades the instruction to plain.
    always_comb begin
        cond_true     = eval_cond(cond, flags);
        br_only       = br_en && !jmp_en && !scond_en;
        jmp_only      = jmp_en && !br_en && !scond_en;
        sc_only       = scond_en && !br_en && !jmp_en;
        is_cond_instr = br_only || jmp_only || sc_only;
        must_wait     = is_cond_instr && (cond != COND_UC) && flag_pend;
        pc_inc        = pc_q + PC_W'(1);
        pc_br         = pc_q + disp;
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q <= RUN;
            pc_q    <= RST_PC;
            fcnt_q  <= '0;
            ack_q   <= 1'b0;
            flush_q <= 1'b0;
            taken_q <= 1'b0;
            scond_q <= 1'b0;
        end else begin
            ack_q   <= 1'b0;
            taken_q <= 1'b0;
            scond_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (!stall && instr_valid) begin
                        if (must_wait) begin
                            state_q <= WAIT_FLAG;
                        end else begin
                            ack_q <= 1'b1;
                            if ((br_only || jmp_only) && cond_true) begin
                                pc_q    <= br_only ? pc_br : target;
                                taken_q <= 1'b1;
                                flush_q <= 1'b1;
                                fcnt_q  <= FLUSH_LAST;
                                state_q <= FLUSH;
                            end else begin
                                pc_q    <= pc_inc;
                                scond_q <= sc_only && cond_true;
                            end
                        end
                    end
                end
                // Upstream holds the instruction; it is re-evaluated in RUN.
                WAIT_FLAG: begin
                    if (!flag_pend && !stall) begin
                        state_q <= RUN;
                    end
                end
                FLUSH: begin
                    if (!stall) begin
                        if (fcnt_q == 2'd0) begin
                            flush_q <= 1'b0;
                            state_q <= RUN;
                        end else begin
                            fcnt_q <= fcnt_q - 2'd1;
                        end
                    end
                end
                default: begin
                    state_q <= RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = pc_q;
    assign instr_ack = ack_q;
    assign flush     = flush_q;
    assign taken     = taken_q;
    assign scond_val = scond_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: per-cycle stimulus with expected
// registered outputs queued at drive time and checked after the clock edge.
module tb_branch_pc_unit;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        instr_valid, br_en, jmp_en, scond_en;
    logic [3:0]  cond;
    logic [15:0] disp, target;
    logic [4:0]  flags;
    logic        flag_pend, stall;
    logic [15:0] pc;
    logic        instr_ack, flush, taken, scond_val;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        rstn;
        logic        valid;
        logic        br;
        logic        jmp;
        logic        sc;
        logic [3:0]  cnd;
        logic [15:0] dsp;
        logic [15:0] tgt;
        logic [4:0]  flg;
        logic        pend;
        logic        stl;
    } stim_t;

    typedef struct packed {
        logic [15:0] pc;
        logic        ack;
        logic        fl;
        logic        tk;
        logic        sv;
    } obs_t;

    obs_t sb[$];

    branch_pc_unit #(.PC_W(16), .FLUSH_CYC(2), .RESET_PC(0)) dut (
        .CLK(CLK), .RESETn(RESETn), .instr_valid(instr_valid), .br_en(br_en),
        .jmp_en(jmp_en), .scond_en(scond_en), .cond(cond), .disp(disp),
        .target(target), .flags(flags), .flag_pend(flag_pend), .stall(stall),
        .pc(pc), .instr_ack(instr_ack), .flush(flush), .taken(taken),
        .scond_val(scond_val)
    );

    always #5 CLK = ~CLK;

    function automatic stim_t S(input logic rstn, input logic valid, input logic br,
                                input logic jmp, input logic sc, input logic [3:0] cnd,
                                input logic [15:0] dsp, input logic [15:0] tgt,
                                input logic [4:0] flg, input logic pend, input logic stl);
        stim_t s;
        s = '{rstn, valid, br, jmp, sc, cnd, dsp, tgt, flg, pend, stl};
        return s;
    endfunction

    function automatic obs_t E(input logic [15:0] p, input logic a, input logic f,
                               input logic t, input logic v);
        obs_t o;
        o = '{p, a, f, t, v};
        return o;
    endfunction

    function automatic obs_t cur();
        obs_t o;
        o = '{pc, instr_ack, flush, taken, scond_val};
        return o;
    endfunction

    task automatic drive(input stim_t s);
        RESETn      = s.rstn;
        instr_valid = s.valid;
        br_en       = s.br;
        jmp_en      = s.jmp;
        scond_en    = s.sc;
        cond        = s.cnd;
        disp        = s.dsp;
        target      = s.tgt;
        flags       = s.flg;
        flag_pend   = s.pend;
        stall       = s.stl;
    endtask

    stim_t IDLE;
    stim_t PLAIN;

    task automatic test_reset();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(0, 1, 0, 1, 0, 4'hE, 16'h0, 16'h1234, 5'h1F, 0, 0)); ex.push_back(E(16'h0, 0, 0, 0, 0));
        st.push_back(S(0, 1, 1, 0, 0, 4'hE, 16'h0040, 16'h0, 5'h1F, 0, 0)); ex.push_back(E(16'h0, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); sb.push_back(ex[i]);
            @(posedge CLK); #1;
            got = cur(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset[%0d] got {pc,ack,flush,taken,scond}=%h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_plain();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(PLAIN); ex.push_back(E(16'h1, 1, 0, 0, 0));
        st.push_back(PLAIN); ex.push_back(E(16'h2, 1, 0, 0, 0));
        st.push_back(PLAIN); ex.push_back(E(16'h3, 1, 0, 0, 0));
        st.push_back(IDLE);  ex.push_back(E(16'h3, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); sb.push_back(ex[i]);
            @(posedge CLK); #1;
            got = cur(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL plain[%0d] got {pc,ack,flush,taken,scond}=%h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_branch_taken();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(1, 1, 0, 1, 0, 4'hE, 16'h0, 16'h0010, 5'h0, 0, 0)); ex.push_back(E(16'h0010, 1, 1, 1, 0));
        st.push_back(PLAIN); ex.push_back(E(16'h0010, 0, 1, 0, 0));
        st.push_back(PLAIN); ex.push_back(E(16'h0010, 0, 0, 0, 0));
        st.push_back(S(1, 1, 1, 0, 0, 4'h0, 16'hFFF8, 16'h0, 5'b00001, 0, 0)); ex.push_back(E(16'h0008, 1, 1, 1, 0));
        st.push_back(PLAIN); ex.push_back(E(16'h0008, 0, 1, 0, 0));
        st.push_back(PLAIN); ex.push_back(E(16'h0008, 0, 0, 0, 0));
        st.push_back(PLAIN); ex.push_back(E(16'h0009, 1, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); sb.push_back(ex[i]);
            @(posedge CLK); #1;
            got = cur(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL branch_taken[%0d] got {pc,ack,flush,taken,scond}=%h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_not_taken();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(1, 1, 0, 1, 0, 4'hE, 16'h0, 16'h0040, 5'h0, 0, 0)); ex.push_back(E(16'h0040, 1, 1, 1, 0));
        st.push_back(IDLE); ex.push_back(E(16'h0040, 0, 1, 0, 0));
        st.push_back(IDLE); ex.push_back(E(16'h0040, 0, 0, 0, 0));
        st.push_back(S(1, 1, 1, 0, 0, 4'h0, 16'h0020, 16'h0, 5'h00, 0, 0)); ex.push_back(E(16'h0041, 1, 0, 0, 0));
        st.push_back(S(1, 1, 0, 1, 0, 4'hF, 16'h0, 16'h1000, 5'h1F, 0, 0)); ex.push_back(E(16'h0042, 1, 0, 0, 0));
        st.push_back(S(1, 1, 1, 0, 0, 4'hB, 16'h0100, 16'h0, 5'h00, 0, 0)); ex.push_back(E(16'h0043, 1, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); sb.push_back(ex[i]);
            @(posedge CLK); #1;
            got = cur(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL not_taken[%0d] got {pc,ack,flush,taken,scond}=%h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_wait_flag();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(1, 1, 0, 1, 0, 4'hA, 16'h0, 16'h1234, 5'b01001, 1, 0)); ex.push_back(E(16'h0043, 0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 1, 0, 4'hA, 16'h0, 16'h1234, 5'b00000, 0, 0)); ex.push_back(E(16'h0043, 0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 1, 0, 4'hA, 16'h0, 16'h1234, 5'b00000, 0, 0)); ex.push_back(E(16'h1234, 1, 1, 1, 0));
        st.push_back(IDLE); ex.push_back(E(16'h1234, 0, 1, 0, 0));
        st.push_back(IDLE); ex.push_back(E(16'h1234, 0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 1, 0, 4'hE, 16'h0, 16'h2000, 5'h00, 1, 0)); ex.push_back(E(16'h2000, 1, 1, 1, 0));
        st.push_back(IDLE); ex.push_back(E(16'h2000, 0, 1, 0, 0));
        st.push_back(IDLE); ex.push_back(E(16'h2000, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); sb.push_back(ex[i]);
            @(posedge CLK); #1;
            got = cur(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL wait_flag[%0d] got {pc,ack,flush,taken,scond}=%h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_scond();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(1, 1, 0, 0, 1, 4'hD, 16'h0, 16'h0, 5'b00001, 0, 0)); ex.push_back(E(16'h2001, 1, 0, 0, 1));
        st.push_back(S(1, 1, 0, 0, 1, 4'hF, 16'h0, 16'h0, 5'b11111, 0, 0)); ex.push_back(E(16'h2002, 1, 0, 0, 0));
        st.push_back(S(1, 1, 0, 0, 1, 4'hC, 16'h0, 16'h0, 5'b00000, 0, 0)); ex.push_back(E(16'h2003, 1, 0, 0, 1));
        st.push_back(S(1, 1, 0, 0, 1, 4'h0, 16'h0, 16'h0, 5'b00000, 1, 0)); ex.push_back(E(16'h2003, 0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 0, 1, 4'h0, 16'h0, 16'h0, 5'b00001, 0, 1)); ex.push_back(E(16'h2003, 0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 0, 1, 4'h0, 16'h0, 16'h0, 5'b00001, 0, 0)); ex.push_back(E(16'h2003, 0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 0, 1, 4'h0, 16'h0, 16'h0, 5'b00001, 0, 0)); ex.push_back(E(16'h2004, 1, 0, 0, 1));
        st.push_back(S(1, 1, 1, 1, 0, 4'hE, 16'h0100, 16'h5555, 5'h1F, 0, 0)); ex.push_back(E(16'h2005, 1, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); sb.push_back(ex[i]);
            @(posedge CLK); #1;
            got = cur(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL scond[%0d] got {pc,ack,flush,taken,scond}=%h want %h", i, got, want);
            end
        end
    endtask

    // Bit k of each table is the condition-k result for the paired flag pattern.
    task automatic test_conds();
        logic [4:0]  fpat [2];
        logic [15:0] tbl  [2];
        logic [15:0] epc;
        obs_t        got, want;
        fpat[0] = 5'b01010; tbl[0] = 16'h6A5A;
        fpat[1] = 5'b10101; tbl[1] = 16'h69A5;
        epc = 16'h2005;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 16; c++) begin
                epc = epc + 16'h1;
                drive(S(1, 1, 0, 0, 1, 4'(c), 16'h0, 16'h0, fpat[p], 0, 0));
                sb.push_back(E(epc, 1, 0, 0, tbl[p][c]));
                @(posedge CLK); #1;
                got = cur(); want = sb.pop_front(); n_run++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL cond[%0d] flags=%b got {pc,ack,flush,taken,scond}=%h want %h", c, fpat[p], got, want);
                end
            end
        end
    endtask

    task automatic test_reset_flush();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(1, 1, 0, 1, 0, 4'hE, 16'h0, 16'h0100, 5'h0, 0, 0)); ex.push_back(E(16'h0100, 1, 1, 1, 0));
        st.push_back(S(0, 1, 0, 0, 0, 4'h0, 16'h0, 16'h0, 5'h0, 0, 0)); ex.push_back(E(16'h0000, 0, 0, 0, 0));
        st.push_back(PLAIN); ex.push_back(E(16'h0001, 1, 0, 0, 0));
        st.push_back(S(1, 1, 0, 1, 0, 4'h0, 16'h0, 16'h0700, 5'h1F, 1, 0)); ex.push_back(E(16'h0001, 0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 5'h0, 1, 0)); ex.push_back(E(16'h0000, 0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 0, 0, 4'h0, 16'h0, 16'h0, 5'h0, 1, 0)); ex.push_back(E(16'h0001, 1, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); sb.push_back(ex[i]);
            @(posedge CLK); #1;
            got = cur(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_flush[%0d] got {pc,ack,flush,taken,scond}=%h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_stall();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        for (int k = 0; k < 4; k++) begin
            st.push_back(S(1, 1, 0, 0, 0, 4'h0, 16'h0, 16'h0, 5'h0, 0, 1)); ex.push_back(E(16'h0001, 0, 0, 0, 0));
        end
        st.push_back(PLAIN); ex.push_back(E(16'h0002, 1, 0, 0, 0));
        st.push_back(S(1, 1, 0, 1, 0, 4'hE, 16'h0, 16'h0030, 5'h0, 0, 1)); ex.push_back(E(16'h0002, 0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 1, 0, 4'hE, 16'h0, 16'h0030, 5'h0, 0, 0)); ex.push_back(E(16'h0030, 1, 1, 1, 0));
        st.push_back(S(1, 1, 0, 0, 0, 4'h0, 16'h0, 16'h0, 5'h0, 0, 1)); ex.push_back(E(16'h0030, 0, 1, 0, 0));
        st.push_back(S(1, 1, 0, 0, 0, 4'h0, 16'h0, 16'h0, 5'h0, 0, 1)); ex.push_back(E(16'h0030, 0, 1, 0, 0));
        st.push_back(IDLE); ex.push_back(E(16'h0030, 0, 1, 0, 0));
        st.push_back(IDLE); ex.push_back(E(16'h0030, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); sb.push_back(ex[i]);
            @(posedge CLK); #1;
            got = cur(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL stall[%0d] got {pc,ack,flush,taken,scond}=%h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(1, 1, 1, 0, 0, 4'h0, 16'h0000, 16'h0, 5'b00001, 0, 0)); ex.push_back(E(16'h0030, 1, 1, 1, 0));
        st.push_back(IDLE); ex.push_back(E(16'h0030, 0, 1, 0, 0));
        st.push_back(IDLE); ex.push_back(E(16'h0030, 0, 0, 0, 0));
        st.push_back(S(1, 1, 1, 0, 0, 4'hE, 16'hFFD0, 16'h0, 5'h0, 0, 0)); ex.push_back(E(16'h0000, 1, 1, 1, 0));
        st.push_back(IDLE); ex.push_back(E(16'h0000, 0, 1, 0, 0));
        st.push_back(IDLE); ex.push_back(E(16'h0000, 0, 0, 0, 0));
        st.push_back(S(1, 1, 1, 0, 0, 4'hE, 16'hFFFF, 16'h0, 5'h0, 0, 0)); ex.push_back(E(16'hFFFF, 1, 1, 1, 0));
        st.push_back(IDLE); ex.push_back(E(16'hFFFF, 0, 1, 0, 0));
        st.push_back(IDLE); ex.push_back(E(16'hFFFF, 0, 0, 0, 0));
        st.push_back(PLAIN); ex.push_back(E(16'h0000, 1, 0, 0, 0));
        st.push_back(PLAIN); ex.push_back(E(16'h0001, 1, 0, 0, 0));
        st.push_back(S(1, 1, 1, 0, 0, 4'h1, 16'h0005, 16'h0, 5'h0, 0, 0)); ex.push_back(E(16'h0006, 1, 1, 1, 0));
        st.push_back(PLAIN); ex.push_back(E(16'h0006, 0, 1, 0, 0));
        st.push_back(PLAIN); ex.push_back(E(16'h0006, 0, 0, 0, 0));
        st.push_back(PLAIN); ex.push_back(E(16'h0007, 1, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); sb.push_back(ex[i]);
            @(posedge CLK); #1;
            got = cur(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back[%0d] got {pc,ack,flush,taken,scond}=%h want %h", i, got, want);
            end
        end
    endtask

    initial begin
        IDLE  = S(1, 0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 5'h0, 0, 0);
        PLAIN = S(1, 1, 0, 0, 0, 4'h0, 16'h0, 16'h0, 5'h0, 0, 0);
        drive(S(0, 0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 5'h0, 0, 0));
        #1;
        test_reset();
        test_plain();
        test_branch_taken();
        test_not_taken();
        test_wait_flag();
        test_scond();
        test_conds();
        test_reset_flush();
        test_stall();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
